// File: rtl/tone_period_meter.sv
// Measures the period of an asynchronous square wave in clk cycles and flags lock
// once enough consecutive periods fall inside the nominal window.
module tone_period_meter #(
    parameter int CNT_W       = 12,
    parameter int NOMINAL     = 1250,
    parameter int TOL         = 25,
    parameter int TIMEOUT_CYC = 4095,
    parameter int LOCK_COUNT  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [31:0] WIN_LO = (NOMINAL > TOL) ? 32'(NOMINAL - TOL) : 32'd0;
    localparam logic [31:0] WIN_HI = 32'(NOMINAL + TOL);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

    state_t            state, state_next;
    logic              sync1, sync2, sync3;
    logic              edge_det;
    logic              in_window;
    logic [31:0]       cnt_ext;
    logic [CNT_W-1:0]  counter, counter_next;
    logic [CNT_W-1:0]  period_next;
    logic [GOOD_W-1:0] good_cnt, good_next;
    logic              period_valid_next, locked_next, timeout_next;

    // sync1/sync2 resolve metastability; sync3 is the edge-detect history flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_det  = sync2 & ~sync3;
    assign cnt_ext   = 32'(counter);
    assign in_window = (cnt_ext >= WIN_LO) && (cnt_ext <= WIN_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= '0;
            good_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_next;
            counter      <= counter_next;
            good_cnt     <= good_next;
            period       <= period_next;
            period_valid <= period_valid_next;
            locked       <= locked_next;
            timeout      <= timeout_next;
        end
    end

    always_comb begin
        state_next        = state;
        counter_next      = counter;
        good_next         = good_cnt;
        period_next       = period;
        period_valid_next = 1'b0;
        locked_next       = locked;
        timeout_next      = 1'b0;

        if (!enable) begin
            state_next   = IDLE;
            counter_next = '0;
            good_next    = '0;
            locked_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    counter_next = '0;
                    state_next   = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (edge_det) begin
                        counter_next = CNT_W'(1);
                        state_next   = MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge takes priority over a coincident timeout
                    if (edge_det) begin
                        period_next       = counter;
                        period_valid_next = 1'b1;
                        counter_next      = CNT_W'(1);
                        if (in_window) begin
                            if (good_cnt != GOOD_W'(LOCK_COUNT)) begin
                                good_next = good_cnt + GOOD_W'(1);
                            end
                            locked_next = (good_next == GOOD_W'(LOCK_COUNT));
                        end else begin
                            good_next   = '0;
                            locked_next = 1'b0;
                        end
                    end else if (counter == CNT_W'(TIMEOUT_CYC)) begin
                        timeout_next = 1'b1;
                        locked_next  = 1'b0;
                        good_next    = '0;
                        counter_next = '0;
                        state_next   = WAIT_EDGE;
                    end else begin
                        counter_next = counter + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: lock acquisition, window edges, timeout,
// edge-beats-timeout, disable and asynchronous reset.
module tb_tone_period_meter;

    localparam int HI = 625;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sig_in = 1'b0;
    logic [11:0] period;
    logic        period_valid, locked, timeout;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int pv_count = 0, to_count = 0, both_count = 0;
    int last_period = 0, last_locked = 0, last_pv_cyc = 0, last_to_cyc = 0;
    int pv_before, to_before, rise_keep;

    tone_period_meter dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sig_in(sig_in),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (period_valid) begin
            pv_count++;
            last_period = int'(period);
            last_locked = int'(locked);
            last_pv_cyc = cyc;
            $display("period_valid: cyc=%0d period=%0d locked=%0d", cyc, period, locked);
        end
        if (timeout) begin
            to_count++;
            last_to_cyc = cyc;
            $display("timeout: cyc=%0d", cyc);
        end
        if (period_valid && timeout) both_count++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Low for per-HI cycles, then rise and stay high HI cycles: rises are per apart
    task automatic wave(input int per);
        sig_in = 1'b0;
        repeat (per - HI) tick();
        sig_in = 1'b1;
        rise_cyc = cyc;
        repeat (HI) tick();
    endtask

    // One measured period: strobe 3 cycles after the rise is driven
    task automatic step(input string tag, input int per, input int exp_locked);
        int pv0, to0;
        pv0 = pv_count;
        to0 = to_count;
        wave(per);
        chk({tag, "_pv_count"}, pv_count, pv0 + 1);
        chk({tag, "_period"}, last_period, per);
        chk({tag, "_locked"}, last_locked, exp_locked);
        chk({tag, "_latency"}, last_pv_cyc, rise_cyc + 3);
        chk({tag, "_no_timeout"}, to_count, to0);
    endtask

    initial begin
        // Test 1: reset state, then nominal tone locks on the 8th period
        repeat (5) tick();
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_timeout", int'(timeout), 0);
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        pv_before = pv_count;
        wave(1250);
        chk("t1_prime_no_pv", pv_count, pv_before);
        for (int i = 1; i <= 8; i++) step($sformatf("t1_p%0d", i), 1250, (i == 8) ? 1 : 0);

        // Test 2: window boundaries 1276/1224 out, 1275/1225 in
        step("t2_1276", 1276, 0);
        step("t2_1275", 1275, 0);
        step("t2_1225", 1225, 0);
        step("t2_1224", 1224, 0);
        step("t2_1275b", 1275, 0);
        step("t2_1225b", 1225, 0);
        for (int i = 3; i <= 8; i++) step($sformatf("t2_g%0d", i), 1250, (i == 8) ? 1 : 0);

        // Test 3: one out-of-window period drops lock on its own strobe
        step("t3_1200", 1200, 0);
        for (int i = 1; i <= 8; i++) step($sformatf("t3_p%0d", i), 1250, (i == 8) ? 1 : 0);

        // Test 4: input stalls; timeout 4095 cycles after the last period strobe
        rise_keep = rise_cyc;
        pv_before = pv_count;
        to_before = to_count;
        sig_in = 1'b0;
        repeat (4000) tick();
        chk("t4_to_count", to_count, to_before + 1);
        chk("t4_to_cyc", last_to_cyc, rise_keep + 3 + 4095);
        chk("t4_no_pv", pv_count, pv_before);
        chk("t4_locked", int'(locked), 0);
        wave(1250);
        chk("t4_restart_no_pv", pv_count, pv_before);
        step("t4_restart", 1250, 0);

        // Test 5: edge lands exactly when the counter reaches 4095
        step("t5_4095", 4095, 0);

        // Test 6: disable mid-period, then asynchronous reset mid-MEASURE
        pv_before = pv_count;
        to_before = to_count;
        sig_in = 1'b0;
        repeat (300) tick();
        enable = 1'b0;
        wave(1250);
        wave(1250);
        sig_in = 1'b0;
        repeat (4500) tick();
        chk("t6_dis_no_pv", pv_count, pv_before);
        chk("t6_dis_no_to", to_count, to_before);
        chk("t6_dis_period_held", int'(period), 4095);
        chk("t6_dis_locked", int'(locked), 0);
        enable = 1'b1;
        wave(1250);
        chk("t6_reen_no_pv", pv_count, pv_before);
        step("t6_reen", 1250, 0);
        sig_in = 1'b0;
        repeat (300) tick();
        #2 reset = 1'b0;
        #1;
        chk("t6_arst_period", int'(period), 0);
        chk("t6_arst_valid", int'(period_valid), 0);
        chk("t6_arst_locked", int'(locked), 0);
        chk("t6_arst_timeout", int'(timeout), 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();

        chk("never_both_strobes", both_count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
Receive-side counterpart to the 40 kHz transmit clock divider. Measures the period of an asynchronous square wave from a microphone comparator, in 50 MHz system clock cycles. Reports each measured period with a one-cycle valid strobe. Asserts a lock flag once the incoming tone has held the nominal 40 kHz period (1250 cycles) for a set number of consecutive periods. Sits between the mic comparator input pins and the array processing logic.

Parameters:
CNT_W, 12, width of the period counter and the period output
NOMINAL, 1250, expected period in clk cycles (50 MHz / 40 kHz)
TOL, 25, allowed absolute deviation from NOMINAL for an in-window period
TIMEOUT_CYC, 4095, cycles without a rising edge before timeout; must be < 2^CNT_W
LOCK_COUNT, 8, consecutive in-window periods required to assert locked

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset (block is reset while reset = 0)
enable  input  1  measurement enable, synchronous to clk
sig_in  input  1  comparator output, asynchronous to clk
period  output  CNT_W  last measured period in clk cycles
period_valid  output  1  one-cycle strobe: period updated
locked  output  1  level: LOCK_COUNT consecutive in-window periods seen
timeout  output  1  one-cycle strobe: no edge within TIMEOUT_CYC

Behaviour:
- Reset (reset = 0, asynchronous): the following go to 0 immediately:
  - synchronizer flops, edge-detect flop
  - counter, good_cnt
  - period, period_valid, locked, timeout
  - state goes to IDLE.
- Input path: sig_in passes through a 2-flop synchronizer, then a third flop.
  - edge = sync2 & ~sync3.
  - A rising edge on sig_in is detected 2-3 clk cycles later.
  - Pulses shorter than one clk period may be missed. This is acceptable.
- FSM states: IDLE, WAIT_EDGE, MEASURE.
  - IDLE: counter = 0. Move to WAIT_EDGE when enable = 1.
  - WAIT_EDGE: on edge, counter <= 1 and move to MEASURE.
  - MEASURE, edge cycle: period <= counter, period_valid = 1 on the next cycle, counter <= 1. Stay in MEASURE.
  - MEASURE, no edge: counter increments.
  - Result: edges detected at cycles t0 and t1 give period = t1 - t0.
  - MEASURE, counter == TIMEOUT_CYC with no edge: timeout = 1 for one cycle, locked <= 0, good_cnt <= 0, move to WAIT_EDGE.
  - Edge and counter == TIMEOUT_CYC in the same cycle: the edge wins. A normal measurement is taken and there is no timeout.
  - enable = 0 in any state: move to IDLE next cycle.
    - counter, good_cnt and locked are cleared.
    - period holds its last value.
    - No strobes are generated while disabled.
- Lock logic, evaluated on each measurement:
  - in_window = (|measured - NOMINAL| <= TOL), computed in unsigned arithmetic with no wrap. Defaults: 1225..1275 inclusive.
  - In-window: good_cnt increments, saturating at LOCK_COUNT. locked = 1 when good_cnt == LOCK_COUNT.
  - locked rises in the same cycle as the period_valid strobe of the LOCK_COUNT-th good period.
  - Out-of-window: good_cnt <= 0 and locked <= 0, effective in the same cycle as that period_valid.
- Strobe timing: period_valid and timeout are registered, each exactly one cycle wide, and never both high.
- Counter never wraps: timeout fires at TIMEOUT_CYC, which is below 2^CNT_W.
- Re-enable after disable: the first period_valid needs two detected edges.

Test Plan:
1. Reset low for 5 cycles, then high, enable = 1, sig_in 625 cycles high / 625 low -> period_valid every 1250 cycles with period = 1250; locked = 1 on the 8th period_valid; timeout never asserts.
2. Square wave with period 1276, then 1275, then 1225, then 1224 -> period values match exactly; 1275 and 1225 increment good_cnt; 1276 and 1224 keep locked = 0 and clear good_cnt.
3. Locked at 1250, then one 1200-cycle period -> locked falls in the same cycle as its period_valid; locked re-asserts after 8 more 1250-cycle periods.
4. Locked, then sig_in held low -> timeout strobe exactly 4095 cycles after the last edge-detect cycle; locked = 0; no period_valid; restart needs two edges.
5. Edge arriving exactly at counter = 4095 (period 4095) -> period_valid with period = 4095 and no timeout strobe.
6. enable dropped mid-period, then reset pulled low asynchronously mid-MEASURE -> no strobes while disabled; after the reset edge, all outputs = 0 before the next clk edge; period = 0.
